// File: rtl/load_store_unit_if.sv
// Bundle of request, response and data-memory signals for the load/store unit.
// The master modport is the unit itself; the slave side is execute stage plus memory.
interface load_store_unit_if;
    logic        REQ_valid;
    logic        REQ_ready;
    logic        REQ_is_store;
    logic [2:0]  REQ_funct3;
    logic [31:0] REQ_address;
    logic [31:0] REQ_wdata;
    logic        RSP_valid;
    logic        RSP_ready;
    logic [31:0] RSP_rdata;
    logic [1:0]  RSP_fault;
    logic [1:0]  MEM_read_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_read_address;
    logic [31:0] MEM_read_data;
    logic [1:0]  MEM_write_length;
    logic [31:0] MEM_write_address;
    logic [31:0] MEM_write_data;

    modport master (
        input  REQ_valid, REQ_is_store, REQ_funct3, REQ_address, REQ_wdata,
        input  RSP_ready, MEM_read_data,
        output REQ_ready, RSP_valid, RSP_rdata, RSP_fault,
        output MEM_read_length, MEM_read_signed, MEM_read_address,
        output MEM_write_length, MEM_write_address, MEM_write_data
    );

    modport slave (
        output REQ_valid, REQ_is_store, REQ_funct3, REQ_address, REQ_wdata,
        output RSP_ready, MEM_read_data,
        input  REQ_ready, RSP_valid, RSP_rdata, RSP_fault,
        input  MEM_read_length, MEM_read_signed, MEM_read_address,
        input  MEM_write_length, MEM_write_address, MEM_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RISC-V load/store, checks it, drives the big-endian
// data-memory port for a single ISSUE cycle and returns data/fault on a valid/ready response.
module load_store_unit #(
    parameter int unsigned MEM_BYTES   = 100,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic               SYS_clk,
    input  logic               SYS_reset_n,
    load_store_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  LEN_NONE = 2'b00;
    localparam logic [1:0]  LEN_BYTE = 2'b01;
    localparam logic [1:0]  LEN_HALF = 2'b10;
    localparam logic [1:0]  LEN_WORD = 2'b11;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic        isStore_q, isStore_d;
    logic [1:0]  len_q, len_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  waitCnt_q, waitCnt_d;

    logic [1:0]  reqLen;
    logic [32:0] reqSize;
    logic        reqIllegal;
    logic        reqMisaligned;
    logic        reqOutOfRange;
    logic [1:0]  reqFault;
    logic        reqSigned;
    logic        accessEn;

    // Decode of the live request; the 33-bit sum makes wrap-around addresses fault.
    always_comb begin
        reqLen  = LEN_NONE;
        reqSize = 33'd0;
        case (bus.REQ_funct3[1:0])
            2'b00:   begin reqLen = LEN_BYTE; reqSize = 33'd1; end
            2'b01:   begin reqLen = LEN_HALF; reqSize = 33'd2; end
            2'b10:   begin reqLen = LEN_WORD; reqSize = 33'd4; end
            default: begin reqLen = LEN_NONE; reqSize = 33'd0; end
        endcase
        if (bus.REQ_is_store) begin
            reqIllegal = bus.REQ_funct3[2] || (bus.REQ_funct3[1:0] == 2'b11);
        end else begin
            reqIllegal = (bus.REQ_funct3[1:0] == 2'b11) ||
                         (bus.REQ_funct3[2] && bus.REQ_funct3[1]);
        end
        reqMisaligned = ALIGN_CHECK &&
                        (((reqLen == LEN_HALF) && bus.REQ_address[0]) ||
                         ((reqLen == LEN_WORD) && (bus.REQ_address[1:0] != 2'b00)));
        reqOutOfRange = (({1'b0, bus.REQ_address} + reqSize) > MEM_LIMIT);
        if (reqIllegal) begin
            reqFault = 2'b11;
        end else if (reqMisaligned) begin
            reqFault = 2'b01;
        end else if (reqOutOfRange) begin
            reqFault = 2'b10;
        end else begin
            reqFault = 2'b00;
        end
        reqSigned = !bus.REQ_is_store && !bus.REQ_funct3[2] && (bus.REQ_funct3[1:0] != 2'b10);
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q   <= ST_IDLE;
            isStore_q <= 1'b0;
            len_q     <= LEN_NONE;
            signed_q  <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            fault_q   <= 2'b00;
            rdata_q   <= 32'd0;
            waitCnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            isStore_q <= isStore_d;
            len_q     <= len_d;
            signed_q  <= signed_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fault_q   <= fault_d;
            rdata_q   <= rdata_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Faulted requests skip WAIT but still spend one ISSUE cycle with the
    // memory port gated off, so their response appears one edge after accept.
    always_comb begin
        state_d   = state_q;
        isStore_d = isStore_q;
        len_d     = len_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fault_d   = fault_q;
        rdata_d   = rdata_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_valid) begin
                    isStore_d = bus.REQ_is_store;
                    len_d     = reqLen;
                    signed_d  = reqSigned;
                    addr_d    = bus.REQ_address;
                    wdata_d   = bus.REQ_wdata;
                    fault_d   = reqFault;
                    rdata_d   = 32'd0;
                    waitCnt_d = WAIT_LOAD;
                    if ((reqFault != 2'b00) || (WAIT_CYCLES == 0)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = ST_ISSUE;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ST_ISSUE: begin
                if (!isStore_q && (fault_q == 2'b00)) begin
                    rdata_d = bus.MEM_read_data;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.RSP_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lengths come straight from the state register, so an async reset mid-ISSUE
    // drops them at once and the memory never sees the write edge.
    assign accessEn              = (state_q == ST_ISSUE) && (fault_q == 2'b00);
    assign bus.MEM_read_length   = (accessEn && !isStore_q) ? len_q : LEN_NONE;
    assign bus.MEM_write_length  = (accessEn && isStore_q) ? len_q : LEN_NONE;
    assign bus.MEM_read_signed   = signed_q;
    assign bus.MEM_read_address  = addr_q;
    assign bus.MEM_write_address = addr_q;
    assign bus.MEM_write_data    = wdata_q;
    assign bus.REQ_ready         = (state_q == ST_IDLE) && SYS_reset_n;
    assign bus.RSP_valid         = (state_q == ST_RESP);
    assign bus.RSP_rdata         = rdata_q;
    assign bus.RSP_fault         = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (wait=1/aligned, wait=0/unaligned)
// share one 100-byte big-endian memory model that sign-extends on read_signed.
module tb_load_store_unit;

    logic SYS_clk;
    logic SYS_reset_n;
    logic memInit;
    logic [7:0] mem [0:99];
    int checksTotal;
    int checksPassed;
    int accessCount1;
    int accessCount2;

    load_store_unit_if lsuBus ();
    load_store_unit_if lsuBus2 ();

    load_store_unit #(.MEM_BYTES(100), .WAIT_CYCLES(1), .ALIGN_CHECK(1'b1)) u_dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .bus         (lsuBus.master)
    );

    load_store_unit #(.MEM_BYTES(100), .WAIT_CYCLES(0), .ALIGN_CHECK(1'b0)) u_dutNoAlign (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .bus         (lsuBus2.master)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    function automatic logic [7:0] byteAt(input logic [31:0] a);
        if (a < 32'd100) return mem[a[6:0]];
        return 8'h00;
    endfunction

    function automatic logic [31:0] memRead(input logic [1:0] len, input logic sgn, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (len)
            2'b01: begin
                b = byteAt(a);
                return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'b10: begin
                h = {byteAt(a), byteAt(a + 32'd1)};
                return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            end
            2'b11: return {byteAt(a), byteAt(a + 32'd1), byteAt(a + 32'd2), byteAt(a + 32'd3)};
            default: return 32'h0;
        endcase
    endfunction

    always_comb lsuBus.MEM_read_data  = memRead(lsuBus.MEM_read_length, lsuBus.MEM_read_signed, lsuBus.MEM_read_address);
    always_comb lsuBus2.MEM_read_data = memRead(lsuBus2.MEM_read_length, lsuBus2.MEM_read_signed, lsuBus2.MEM_read_address);

    task putByte(input logic [31:0] a, input logic [7:0] b);
        if (a < 32'd100) mem[a[6:0]] <= b;
    endtask

    task writeMem(input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        case (len)
            2'b01: putByte(a, d[7:0]);
            2'b10: begin putByte(a, d[15:8]); putByte(a + 32'd1, d[7:0]); end
            2'b11: begin
                putByte(a, d[31:24]);          putByte(a + 32'd1, d[23:16]);
                putByte(a + 32'd2, d[15:8]);   putByte(a + 32'd3, d[7:0]);
            end
            default: ;
        endcase
    endtask

    // Memory writes land at the clock edge that closes the ISSUE cycle.
    always @(posedge SYS_clk) begin
        if (memInit) begin
            for (int i = 0; i < 100; i++) mem[i] <= 8'(i);
        end else begin
            writeMem(lsuBus.MEM_write_length, lsuBus.MEM_write_address, lsuBus.MEM_write_data);
            writeMem(lsuBus2.MEM_write_length, lsuBus2.MEM_write_address, lsuBus2.MEM_write_data);
        end
    end

    always @(negedge SYS_clk) begin
        if (lsuBus.MEM_read_length != 2'b00 || lsuBus.MEM_write_length != 2'b00) accessCount1++;
        if (lsuBus2.MEM_read_length != 2'b00 || lsuBus2.MEM_write_length != 2'b00) accessCount2++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end else begin
            checksPassed++;
        end
    endtask

    function automatic logic rspValid(input int sel);
        return (sel == 1) ? lsuBus.RSP_valid : lsuBus2.RSP_valid;
    endfunction

    function automatic logic reqReady(input int sel);
        return (sel == 1) ? lsuBus.REQ_ready : lsuBus2.REQ_ready;
    endfunction

    task automatic setReqFields(input int sel, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 1) begin
            lsuBus.REQ_is_store = st;  lsuBus.REQ_funct3 = f3;
            lsuBus.REQ_address = addr; lsuBus.REQ_wdata = wdata;
        end else begin
            lsuBus2.REQ_is_store = st;  lsuBus2.REQ_funct3 = f3;
            lsuBus2.REQ_address = addr; lsuBus2.REQ_wdata = wdata;
        end
    endtask

    // Presents one request for exactly one edge (the accept edge); returns at edge0 + 1.
    task automatic applyStimulus(input int sel, input string tag, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        setReqFields(sel, st, f3, addr, wdata);
        if (sel == 1) lsuBus.REQ_valid = 1'b1; else lsuBus2.REQ_valid = 1'b1;
        checkOutput({tag, "_reqReady"}, 32'(reqReady(sel)), 32'd1);
        @(posedge SYS_clk); #1;
        if (sel == 1) lsuBus.REQ_valid = 1'b0; else lsuBus2.REQ_valid = 1'b0;
    endtask

    task automatic waitResponse(input int sel, input string tag, input int expLat);
        int lat;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (rspValid(sel)) begin
                lat = k;
                break;
            end
            @(posedge SYS_clk); #1;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    endtask

    task automatic finishResponse(input int sel, input string tag,
                                  input logic [31:0] expRdata, input logic [1:0] expFault);
        if (sel == 1) begin
            checkOutput({tag, "_rdata"}, lsuBus.RSP_rdata, expRdata);
            checkOutput({tag, "_fault"}, 32'(lsuBus.RSP_fault), 32'(expFault));
            lsuBus.RSP_ready = 1'b1;
        end else begin
            checkOutput({tag, "_rdata"}, lsuBus2.RSP_rdata, expRdata);
            checkOutput({tag, "_fault"}, 32'(lsuBus2.RSP_fault), 32'(expFault));
            lsuBus2.RSP_ready = 1'b1;
        end
        @(posedge SYS_clk); #1;
        lsuBus.RSP_ready  = 1'b0;
        lsuBus2.RSP_ready = 1'b0;
        checkOutput({tag, "_backToIdle"}, {30'd0, rspValid(sel), reqReady(sel)}, 32'b01);
    endtask

    task automatic doTransaction(input int sel, input string tag, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int expLat,
                                 input logic [31:0] expRdata, input logic [1:0] expFault);
        applyStimulus(sel, tag, st, f3, addr, wdata);
        waitResponse(sel, tag, expLat);
        finishResponse(sel, tag, expRdata, expFault);
    endtask

    function automatic logic [31:0] memWord(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int before1;
        int before2;
        checksTotal = 0;
        checksPassed = 0;
        memInit = 1'b1;
        SYS_reset_n = 1'b0;
        lsuBus.REQ_valid = 1'b0;  lsuBus.RSP_ready = 1'b0;
        lsuBus2.REQ_valid = 1'b0; lsuBus2.RSP_ready = 1'b0;
        setReqFields(1, 1'b0, 3'b000, 32'd0, 32'd0);
        setReqFields(2, 1'b0, 3'b000, 32'd0, 32'd0);

        repeat (3) @(posedge SYS_clk);
        #1;
        checkOutput("rst_reqReady", 32'(lsuBus.REQ_ready), 32'd0);
        checkOutput("rst_rspValid", 32'(lsuBus.RSP_valid), 32'd0);
        checkOutput("rst_rdata", lsuBus.RSP_rdata, 32'd0);
        checkOutput("rst_fault", 32'(lsuBus.RSP_fault), 32'd0);
        checkOutput("rst_lengths", {28'd0, lsuBus.MEM_read_length, lsuBus.MEM_write_length}, 32'd0);
        checkOutput("rst_wrAddr", lsuBus.MEM_write_address, 32'd0);
        memInit = 1'b0;
        SYS_reset_n = 1'b1;
        @(posedge SYS_clk); #1;

        // Basic word store/load with one wait cycle
        doTransaction(1, "sw8", 1'b1, 3'b010, 32'd8, 32'h12345678, 2, 32'h0, 2'b00);
        checkOutput("sw8_mem", memWord(8), 32'h12345678);
        doTransaction(1, "lw8", 1'b0, 3'b010, 32'd8, 32'h0, 2, 32'h12345678, 2'b00);

        // Byte/half stores and sign/zero-extending loads
        doTransaction(1, "sb3", 1'b1, 3'b000, 32'd3, 32'h000000F0, 2, 32'h0, 2'b00);
        doTransaction(1, "lb3", 1'b0, 3'b000, 32'd3, 32'h0, 2, 32'hFFFFFFF0, 2'b00);
        doTransaction(1, "lbu3", 1'b0, 3'b100, 32'd3, 32'h0, 2, 32'h000000F0, 2'b00);
        doTransaction(1, "sh4", 1'b1, 3'b001, 32'd4, 32'h0000BEEF, 2, 32'h0, 2'b00);
        doTransaction(1, "lh4", 1'b0, 3'b001, 32'd4, 32'h0, 2, 32'hFFFFBEEF, 2'b00);
        doTransaction(1, "lhu4", 1'b0, 3'b101, 32'd4, 32'h0, 2, 32'h0000BEEF, 2'b00);

        // Misaligned word: faults with alignment check, succeeds without it
        before1 = accessCount1;
        doTransaction(1, "lw2_align", 1'b0, 3'b010, 32'd2, 32'h0, 1, 32'h0, 2'b01);
        checkOutput("lw2_align_noAccess", 32'(accessCount1 - before1), 32'd0);
        doTransaction(2, "lw2_noAlign", 1'b0, 3'b010, 32'd2, 32'h0, 1, 32'h02F0BEEF, 2'b00);

        // Range edges, wrap-around, illegal funct3 and fault priority
        before2 = accessCount2;
        doTransaction(2, "sw98", 1'b1, 3'b010, 32'd98, 32'hAABBCCDD, 1, 32'h0, 2'b10);
        checkOutput("sw98_noAccess", 32'(accessCount2 - before2), 32'd0);
        checkOutput("sw98_mem", {16'h0, mem[98], mem[99]}, 32'h00006263);
        doTransaction(1, "lw96", 1'b0, 3'b010, 32'd96, 32'h0, 2, 32'h60616263, 2'b00);
        doTransaction(1, "lb100", 1'b0, 3'b000, 32'd100, 32'h0, 1, 32'h0, 2'b10);
        doTransaction(1, "lhWrap", 1'b0, 3'b001, 32'hFFFFFFFE, 32'h0, 1, 32'h0, 2'b10);
        doTransaction(1, "swWrapMis", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 32'h0, 2'b01);
        doTransaction(1, "sIllegal", 1'b1, 3'b100, 32'd0, 32'h0, 1, 32'h0, 2'b11);
        doTransaction(1, "lIllegal", 1'b0, 3'b110, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 2'b11);

        // Response backpressure: outputs hold, new requests ignored incl. handshake cycle
        before1 = accessCount1;
        applyStimulus(1, "hold", 1'b0, 3'b010, 32'd8, 32'h0);
        waitResponse(1, "hold", 2);
        setReqFields(1, 1'b1, 3'b010, 32'd0, 32'hDEADBEEF);
        lsuBus.REQ_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_valid", 32'(lsuBus.RSP_valid), 32'd1);
            checkOutput("hold_rdata", lsuBus.RSP_rdata, 32'h12345678);
            checkOutput("hold_reqReady", 32'(lsuBus.REQ_ready), 32'd0);
            @(posedge SYS_clk); #1;
        end
        finishResponse(1, "hold", 32'h12345678, 2'b00);
        lsuBus.REQ_valid = 1'b0;
        repeat (4) @(posedge SYS_clk);
        #1;
        checkOutput("hold_memUntouched", memWord(0), 32'h000102F0);
        checkOutput("hold_accessCount", 32'(accessCount1 - before1), 32'd1);

        // Reset during WAIT
        applyStimulus(1, "rstWait", 1'b1, 3'b010, 32'd12, 32'hCAFEF00D);
        SYS_reset_n = 1'b0;
        #1;
        checkOutput("rstWait_rspValid", 32'(lsuBus.RSP_valid), 32'd0);
        checkOutput("rstWait_reqReady", 32'(lsuBus.REQ_ready), 32'd0);
        repeat (2) @(posedge SYS_clk);
        #1;
        SYS_reset_n = 1'b1;
        @(posedge SYS_clk); #1;
        checkOutput("rstWait_reqReadyAfter", 32'(lsuBus.REQ_ready), 32'd1);
        checkOutput("rstWait_mem", memWord(12), 32'h0C0D0E0F);

        // Reset during ISSUE: the write must be suppressed
        applyStimulus(1, "rstIssue", 1'b1, 3'b010, 32'd12, 32'hCAFEF00D);
        @(posedge SYS_clk); #1;
        checkOutput("rstIssue_inIssue", 32'(lsuBus.MEM_write_length), 32'd3);
        SYS_reset_n = 1'b0;
        #1;
        checkOutput("rstIssue_lenDropped", 32'(lsuBus.MEM_write_length), 32'd0);
        checkOutput("rstIssue_rspValid", 32'(lsuBus.RSP_valid), 32'd0);
        repeat (2) @(posedge SYS_clk);
        #1;
        SYS_reset_n = 1'b1;
        @(posedge SYS_clk); #1;
        checkOutput("rstIssue_reqReadyAfter", 32'(lsuBus.REQ_ready), 32'd1);
        checkOutput("rstIssue_mem", memWord(12), 32'h0C0D0E0F);
        doTransaction(1, "lw12", 1'b0, 3'b010, 32'd12, 32'h0, 2, 32'h0C0D0E0F, 2'b00);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
